// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one rs232send transmitter between N_REQ byte producers.
// Latency: grant one edge after req is seen in IDLE, start_send one cycle later, then a full frame hold-off.
// Backpressure: requesters hold req until granted; busy covers grant through the end of the frame hold-off.
module rs232_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         cur_src,
  output logic               busy,
  output logic [7:0]         data,
  output logic               start_send
);

  localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS + GAP_CLKS;
  localparam int CW         = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_WAIT
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         ptr_q;
  logic [N_REQ-1:0]   grant_q;
  logic [2:0]         cur_src_q;
  logic               busy_q;
  logic [7:0]         data_q;
  logic               start_q;

  // Zero-extended copies so a 3-bit index always selects legally.
  logic [7:0]         req_ext;
  logic [63:0]        data_ext;
  logic [3:0]         idx_w;
  logic [3:0]         ptr_inc;
  logic               sel_vld_d;
  logic [2:0]         sel_idx_d;
  logic [2:0]         ptr_d;
  logic [N_REQ-1:0]   grant_d;
  logic [7:0]         data_d;

  assign req_ext  = 8'(req);
  assign data_ext = 64'(req_data);

  // Pick the first active requester at or after the round-robin pointer.
  always_comb begin
    sel_vld_d = 1'b0;
    sel_idx_d = 3'd0;
    idx_w     = 4'd0;
    // Scan from the far end so the closest candidate to ptr wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, ptr_q} + 4'(k);
      if (idx_w >= 4'(N_REQ)) begin
        idx_w = idx_w - 4'(N_REQ);
      end
      if (req_ext[idx_w[2:0]]) begin
        sel_vld_d = 1'b1;
        sel_idx_d = idx_w[2:0];
      end
    end
    ptr_inc = {1'b0, sel_idx_d} + 4'd1;
    ptr_d   = (ptr_inc >= 4'(N_REQ)) ? 3'd0 : ptr_inc[2:0];
    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_d;
    data_d  = data_ext[{sel_idx_d, 3'b000} +: 8];
  end

  // Arbitration and frame pacing FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 3'd0;
      grant_q   <= '0;
      cur_src_q <= 3'd0;
      busy_q    <= 1'b0;
      data_q    <= 8'd0;
      start_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_vld_d) begin
            grant_q   <= grant_d;
            data_q    <= data_d;
            cur_src_q <= sel_idx_d;
            busy_q    <= 1'b1;
            ptr_q     <= ptr_d;
            state_q   <= S_SETUP;
          end
        end
        // data has now been stable for a full cycle; fire the start pulse.
        S_SETUP: begin
          grant_q <= '0;
          start_q <= 1'b1;
          state_q <= S_FIRE;
        end
        S_FIRE: begin
          start_q <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= S_WAIT;
        end
        // rs232send has no busy flag, so the frame time is counted here.
        S_WAIT: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign cur_src    = cur_src_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign start_send = start_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: random and directed requests against a round-robin transaction model.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_rs232_tx_arbiter;

  localparam int N_REQ      = 4;
  localparam int CPB        = 4;
  localparam int FB         = 10;
  localparam int GAP        = 0;
  localparam int FRAME_CLKS = CPB * FB + GAP;
  localparam int BUSY_LEN   = FRAME_CLKS + 2;
  localparam int START_GAP  = FRAME_CLKS + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [2:0]  cur_src;
  logic        busy;
  logic [7:0]  data;
  logic        start_send;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  rs232_tx_arbiter #(
    .N_REQ(N_REQ), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CLKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .cur_src(cur_src), .busy(busy), .data(data),
    .start_send(start_send)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first set request at p, p+1, ... modulo N_REQ.
  function automatic int rr_pick(input int p, input logic [3:0] m);
    for (int k = 0; k < N_REQ; k++) begin
      if (m[2'((p + k) % N_REQ)]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // mode 0: plain send; 1: req[1] rises mid-WAIT and stays; 2: req[1] pulses mid-WAIT;
  // 3: reset asserted mid-WAIT.
  task automatic run_trial(input logic [3:0] mask, input logic [31:0] bytes, input int mode,
                           output int s);
    int         bcnt, bad_start, bad_grant, bad_data, quiet_bad, s2;
    logic [7:0] exp_d, late_b;
    logic [3:0] exp_g;
    req_data = bytes;
    req      = mask;
    @(negedge clk);
    s     = rr_pick(ptr_m, mask);
    exp_d = 8'(bytes >> (8 * s));
    exp_g = 4'b0001 << s;
    chk("grant", grant, exp_g);
    chk("data", data, exp_d);
    chk("cur_src", cur_src, s);
    chk("busy_on", busy, 1);
    chk("start_with_grant", start_send, 0);
    ptr_m  = (s + 1) % N_REQ;
    req    = '0;
    late_b = 8'($urandom);
    bcnt = 0; bad_start = 0; bad_grant = 0; bad_data = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      if (bcnt == 2) chk("start_pulse", start_send, 1);
      else if (start_send) bad_start++;
      if (bcnt > 1 && grant != 4'd0) bad_grant++;
      if (data !== exp_d) bad_data++;
      if ((mode == 1 || mode == 2) && bcnt == 10) begin
        req[1] = 1'b1;
        req_data[15:8] = late_b;
      end
      if (mode == 2 && bcnt == 30) req[1] = 1'b0;
      if (mode == 3 && bcnt == 20) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", start_send, 0);
        chk("rst_grant", grant, 0);
        chk("rst_data", data, 0);
        chk("rst_cur_src", cur_src, 0);
        @(negedge clk);
        rst   = 1'b0;
        req   = '0;
        ptr_m = 0;
        return;
      end
      @(negedge clk);
    end
    chk("busy_len", bcnt, BUSY_LEN);
    chk("start_single", bad_start, 0);
    chk("grant_quiet", bad_grant, 0);
    chk("data_stable", bad_data, 0);
    if (mode == 1) begin
      @(negedge clk);
      s2    = rr_pick(ptr_m, 4'b0010);
      exp_g = 4'b0001 << s2;
      chk("late_grant", grant, exp_g);
      chk("late_data", data, late_b);
      ptr_m = (s2 + 1) % N_REQ;
      req   = '0;
      wait_idle();
    end
    if (mode == 2) begin
      quiet_bad = 0;
      repeat (6) begin
        if (grant != 4'd0 || start_send) quiet_bad++;
        @(negedge clk);
      end
      chk("withdraw_quiet", quiet_bad, 0);
    end
  endtask

  task automatic run_continuous();
    int         cyc, ns, last_start, bad, s;
    logic [7:0] prev_d, exp_d;
    int         order[$];
    logic [7:0] gdata[$];
    logic [31:0] bytes;
    bytes    = 32'h4443_4241;
    req_data = bytes;
    req      = 4'hF;
    prev_d = data; cyc = 0; ns = 0; last_start = -1; bad = 0;
    while (ns < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (grant != 4'd0) begin
        if (!$onehot(grant)) bad++;
        order.push_back($clog2(grant));
        gdata.push_back(data);
      end
      if (grant != 4'd0 && start_send) bad++;
      if (data !== prev_d && grant == 4'd0) bad++;
      prev_d = data;
      if (start_send) begin
        if (last_start >= 0) chk("start_gap", cyc - last_start, START_GAP);
        last_start = cyc;
        ns++;
      end
    end
    req = '0;
    chk("cont_starts", ns, 5);
    chk("cont_grants", order.size(), 5);
    chk("cont_protocol", bad, 0);
    foreach (order[i]) begin
      s     = rr_pick(ptr_m, 4'hF);
      exp_d = 8'(bytes >> (8 * s));
      chk("cont_order", order[i], s);
      chk("cont_data", gdata[i], exp_d);
      ptr_m = (s + 1) % N_REQ;
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; req = '0; req_data = '0;
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", data, 0);
    chk("reset_start", start_send, 0);
    chk("reset_cur_src", cur_src, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single send of 'A' from requester 2.
    run_trial(4'b0100, 32'h0041_0000, 0, s);
    // Fairness after wrap: 3 then {0,3} must pick 0.
    run_trial(4'b1000, $urandom, 0, s);
    run_trial(4'b1001, $urandom, 0, s);
    // Request arriving during WAIT, then a withdrawn one.
    run_trial(4'b0001, $urandom, 1, s);
    run_trial(4'b0100, $urandom, 2, s);
    // Random request patterns.
    for (int t = 0; t < 8; t++) begin
      run_trial(4'($urandom_range(1, 15)), $urandom, 0, s);
    end
    // Reset mid-WAIT, then all four requesters continuously from ptr 0.
    run_trial(4'b0010, $urandom, 3, s);
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    run_continuous();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
Round-robin arbiter that shares the single rs232send transmitter between N_REQ byte producers (keypad echo, status reporter, debug dumper, etc.).
It latches one requester's byte, drives rs232send's data/start_send with a one-cycle start pulse, then holds off all further sends for a full frame time measured by an internal counter.
rs232send gives no busy indication, so this block is the sole owner of transmitter pacing.
It sits directly between the requester logic and the rs232send instance.

Parameters:
N_REQ, 4, number of requesters (2..8).
CLKS_PER_BIT, 868, clk cycles per serial bit; must match rs232send's bit period; >=1.
FRAME_BITS, 10, bits per frame (start + 8 data + stop).
GAP_CLKS, 0, extra idle clocks appended after each frame.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  N_REQ  per-requester send request; held high until granted.
req_data  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
grant  out  N_REQ  one-hot, one-cycle pulse: requester's byte accepted.
cur_src  out  3  index of most recently granted requester.
busy  out  1  high from grant until transmitter hold-off ends.
data  out  8  byte to rs232send data input.
start_send  out  1  one-cycle pulse to rs232send start_send.

Behaviour:
- Definitions:
  - FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS + GAP_CLKS.
  - The counter width is clog2(FRAME_CLKS) bits; it never wraps.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - grant=0, cur_src=0, busy=0, data=0, start_send=0.
  - State=IDLE, counter=0, round-robin pointer ptr=0.
  - A frame already in flight in rs232send is not tracked after reset.
- IDLE:
  - If any req bit is high, select the first set bit searching ptr, ptr+1, ... modulo N_REQ.
  - At that edge, for the selected index s:
    - grant[s]=1, data<=req_data[s], cur_src<=s, busy<=1.
    - ptr<=(s+1) mod N_REQ.
    - Go to SETUP.
  - If no req bit is high, remain in IDLE with all outputs held.
- SETUP (1 cycle; data stable for a full cycle before the start pulse):
  - grant<=0, start_send<=1.
  - Go to FIRE.
- FIRE (1 cycle):
  - start_send<=0, counter<=FRAME_CLKS-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, at the next edge: busy<=0 and go to IDLE.
- Timing:
  - Grant is registered at the edge after req is sampled in IDLE.
  - start_send goes high 1 cycle after grant.
  - busy stays high for FRAME_CLKS+2 cycles.
  - With continuous requests, start_send pulses are exactly FRAME_CLKS+3 cycles apart.
- data is held constant from grant until the next grant; it never changes during a frame.
- Requests:
  - req changes outside IDLE are ignored.
  - A requester that drops req before grant is treated as withdrawn.
  - After grant, a requester may present a new byte and keep req high; it re-competes in round-robin order.
- Simultaneous requests: exactly one grant per arbitration. With all requesters asserting continuously, the grant order is 0,1,2,3,0,...
- Exactly one grant bit is ever high. grant and start_send are never high in the same cycle.

Test Plan:
Use CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CLKS=0, so FRAME_CLKS=40.
1. Reset: assert rst mid-WAIT -> busy, start_send, grant and data go to 0 immediately without a clock edge. After release, state is IDLE and ptr=0.
2. Single send: req[2]=1 with byte 8'h41 -> grant=4'b0100 one cycle later, data=8'h41. Next cycle start_send=1 for exactly 1 cycle. busy is high for 42 cycles.
3. All four requesters high continuously with bytes 'A','B','C','D' -> grants in order 0,1,2,3,0. start_send pulses are spaced exactly 43 cycles apart. data changes only at grant edges.
4. Fairness after wrap: grant req[3], then assert req[0] and req[3] together -> req[0] is granted next.
5. Request arriving during WAIT: req[1] rises at busy cycle 10 -> no grant until IDLE. It is then granted on the first IDLE edge.
6. Withdrawal: req[1] pulses high only during WAIT and falls before IDLE -> no grant issued and start_send stays 0.
